eightbit_logic_arbiter: RTL and testbench

Shares one 8-bit bitwise logic unit (NOT/AND/OR/XOR, built from the gate library) among NREQ requesters. A round-robin arbiter grants one requester at a time and latches its operands. The block sequences the shared unit through a three-state FSM and presents a registered result, tagged with the requester ID, on a valid/ready output. It sits between several independent clients and the gate-level datapath, so only one copy of the 8-bit datapath exists.

---
 rtl/logic_lib_pkg.sv | 18 +
 rtl/eightbit_logic_unit.sv | 38 +++
 rtl/eightbit_logic_arbiter.sv | 152 +++++++++++++++
 tb/tb_eightbit_logic_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_lib_pkg.sv
// Shared definitions for the shared 8-bit logic unit and its arbiter.
//   OP_*  : 2-bit operation encoding presented on req_op
//   ST_*  : FSM state encoding used by eightbit_logic_arbiter
package logic_lib_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] OP_NOT = 2'b00;
  localparam logic [OP_W-1:0] OP_AND = 2'b01;
  localparam logic [OP_W-1:0] OP_OR  = 2'b10;
  localparam logic [OP_W-1:0] OP_XOR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/eightbit_logic_unit.sv
// Combinational 8-bit bitwise logic unit: NOT a / AND / OR / XOR selected by op.
//   out : result
//   a   : operand a
//   b   : operand b (unused for NOT)
//   op  : operation select (OP_* encoding)
module eightbit_logic_unit
  import logic_lib_pkg::*;
(
  output logic [DATA_W-1:0] out,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op
);

  logic [DATA_W-1:0] w_not;
  logic [DATA_W-1:0] w_and;
  logic [DATA_W-1:0] w_or;
  logic [DATA_W-1:0] w_xor;

  // gate-level bitwise functions
  assign w_not = ~a;
  assign w_and = a & b;
  assign w_or  = a | b;
  assign w_xor = a ^ b;

  // 4:1 result mux
  always_comb begin
    out = w_not;
    case (op)
      OP_NOT: out = w_not;
      OP_AND: out = w_and;
      OP_OR:  out = w_or;
      OP_XOR: out = w_xor;
      default: out = w_not;
    endcase
  end

endmodule

// File: rtl/eightbit_logic_arbiter.sv
// Round-robin arbiter sharing one eightbit_logic_unit among NREQ requesters.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero, combinational)
//   req_op/req_a/req_b  : per-requester packed op and operands
//   res_valid/res_ready : registered result handshake
//   res_data/res_id     : registered result and producing requester index
module eightbit_logic_arbiter
  import logic_lib_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [OP_W*NREQ-1:0]   req_op,
  input  logic [DATA_W*NREQ-1:0] req_a,
  input  logic [DATA_W*NREQ-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_W-1:0]      res_data,
  output logic [IDW-1:0]         res_id
);

  logic [1:0]        r_state,     w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr,    w_rr_ptr_nxt;
  logic [IDW-1:0]    r_win,       w_win_nxt;
  logic [OP_W-1:0]   r_op,        w_op_nxt;
  logic [DATA_W-1:0] r_a,         w_a_nxt;
  logic [DATA_W-1:0] r_b,         w_b_nxt;
  logic              r_res_valid, w_res_valid_nxt;
  logic [DATA_W-1:0] r_res_data,  w_res_data_nxt;
  logic [IDW-1:0]    r_res_id,    w_res_id_nxt;

  logic              w_found;
  logic [IDW-1:0]    w_pick;
  logic [OP_W-1:0]   w_pick_op;
  logic [DATA_W-1:0] w_pick_a;
  logic [DATA_W-1:0] w_pick_b;
  logic [DATA_W-1:0] w_unit_out;

  // first valid requester at or above rr_ptr, wrapping modulo NREQ
  always_comb begin : p_pick
    int unsigned idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(r_rr_ptr) + k) % NREQ;
      if (!w_found && req_valid[IDW'(idx)]) begin
        w_found = 1'b1;
        w_pick  = IDW'(idx);
      end
    end
  end

  // operand select for the winning requester
  always_comb begin
    w_pick_op = '0;
    w_pick_a  = '0;
    w_pick_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_pick == IDW'(i)) begin
        w_pick_op = req_op[OP_W*i +: OP_W];
        w_pick_a  = req_a[DATA_W*i +: DATA_W];
        w_pick_b  = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  eightbit_logic_unit u_unit (
    .out (w_unit_out),
    .a   (r_a),
    .b   (r_b),
    .op  (r_op)
  );

  // next-state and grant logic
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_win_nxt       = r_win;
    w_op_nxt        = r_op;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_res_valid_nxt = r_res_valid;
    w_res_data_nxt  = r_res_data;
    w_res_id_nxt    = r_res_id;
    req_ready       = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          req_ready   = NREQ'(1) << w_pick;
          w_win_nxt   = w_pick;
          w_op_nxt    = w_pick_op;
          w_a_nxt     = w_pick_a;
          w_b_nxt     = w_pick_b;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_res_valid_nxt = 1'b1;
        w_res_data_nxt  = w_unit_out;
        w_res_id_nxt    = r_win;
        w_state_nxt     = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          w_res_valid_nxt = 1'b0;
          // pointer moves past the requester just served, only on completion
          w_rr_ptr_nxt    = (32'(r_win) == NREQ - 1) ? '0 : r_win + IDW'(1);
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (reset) req_ready = '0;
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_win       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_win       <= w_win_nxt;
      r_op        <= w_op_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_data  <= w_res_data_nxt;
      r_res_id    <= w_res_id_nxt;
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_eightbit_logic_arbiter.sv
// Self-checking bench for eightbit_logic_arbiter (NREQ=4).
module tb_eightbit_logic_arbiter;
  import logic_lib_pkg::*;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   valid;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] opv;
  logic [8*N-1:0] av;
  logic [8*N-1:0] bv;
  logic           res_valid;
  logic           res_ready;
  logic [7:0]     res_data;
  logic [1:0]     res_id;

  always #5 clk = ~clk;

  eightbit_logic_arbiter #(.NREQ(N)) dut (
    .clk       (clk),
    .reset     (rst),
    .req_valid (valid),
    .req_ready (req_ready),
    .req_op    (opv),
    .req_a     (av),
    .req_b     (bv),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  int total = 0;
  int bad   = 0;

  // reference model: phase 0 waiting for a request, 1 computing, 2 result offered
  int         m_phase = 0;
  int         m_ptr   = 0;
  int         m_win   = 0;
  logic [1:0] m_op    = '0;
  logic [7:0] m_a     = '0;
  logic [7:0] m_b     = '0;
  logic       m_rv    = 1'b0;
  logic [7:0] m_rd    = '0;
  int         m_rid   = 0;

  int         cyc = 0;
  int         last_gnt = -1;
  int         last_gnt_cyc = 0;
  int         last_fire_cyc = 0;
  int         fid[$];
  logic [7:0] fdat[$];
  int         gnt_q[$];

  typedef struct {
    int         id;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [7:0] ref_fn(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      2'b00:   return ~a;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(int i, logic [1:0] op, logic [7:0] a, logic [7:0] b);
    opv[2*i +: 2] = op;
    av[8*i +: 8]  = a;
    bv[8*i +: 8]  = b;
  endtask

  // one clock: check outputs against the model, then advance the model on the edge
  task automatic step();
    logic [N-1:0] er;
    int w;
    int idx;
    #1;
    w = -1;
    if (!rst && m_phase == 0) begin
      for (int k = 0; k < int'(N); k++) begin
        idx = (m_ptr + k) % int'(N);
        if (w < 0 && valid[idx]) w = idx;
      end
    end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("res_valid", 32'(res_valid), 32'(m_rv));
    if (m_rv) begin
      chk("res_data", 32'(res_data), 32'(m_rd));
      chk("res_id", 32'(res_id), 32'(m_rid));
    end
    if (res_valid && res_ready && !rst) begin
      fid.push_back(int'(res_id));
      fdat.push_back(res_data);
      last_fire_cyc = cyc;
    end
    last_gnt = w;
    if (w >= 0) begin
      gnt_q.push_back(w);
      last_gnt_cyc = cyc;
    end
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_rv = 1'b0; m_rd = '0; m_rid = 0;
    end else begin
      case (m_phase)
        0: if (w >= 0) begin
             m_win = w; m_op = opv[2*w +: 2]; m_a = av[8*w +: 8]; m_b = bv[8*w +: 8];
             m_phase = 1;
           end
        1: begin
             m_rv = 1'b1; m_rd = ref_fn(m_op, m_a, m_b); m_rid = m_win; m_phase = 2;
           end
        default: if (res_ready) begin
             m_rv = 1'b0; m_ptr = (m_win + 1) % int'(N); m_phase = 0;
           end
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_ids[4];
    logic [7:0] exp_dat[4];

    tbl[0] = '{0, OP_NOT, 8'hA5, 8'h00, 8'h5A};
    tbl[1] = '{1, OP_AND, 8'hF0, 8'h3C, 8'h30};
    tbl[2] = '{2, OP_OR,  8'hF0, 8'h0F, 8'hFF};
    tbl[3] = '{3, OP_XOR, 8'hFF, 8'h0F, 8'hF0};
    tbl[4] = '{2, OP_AND, 8'hCC, 8'hAA, 8'h88};
    tbl[5] = '{3, OP_NOT, 8'h00, 8'hFF, 8'hFF};

    rst = 1'b1; valid = '1; res_ready = 1'b0; opv = '0; av = '0; bv = '0;
    @(posedge clk);
    @(negedge clk);
    step();
    chk("reset res_data", 32'(res_data), 32'h0);
    chk("reset res_id", 32'(res_id), 32'h0);
    rst = 1'b0;
    valid = '0;

    // single-requester vectors
    for (int t = 0; t < 6; t++) begin
      valid = '0;
      set_req(tbl[t].id, tbl[t].op, tbl[t].a, tbl[t].b);
      valid[tbl[t].id] = 1'b1;
      res_ready = 1'b1;
      fid.delete(); fdat.delete();
      n = 0;
      while (fid.size() == 0 && n < 12) begin
        step();
        if (last_gnt >= 0) valid = '0;
        n++;
      end
      if (fid.size() == 0) begin
        chk("vec timeout", 32'(t), 32'hFFFF_FFFF);
      end else begin
        chk("vec data", 32'(fdat[0]), 32'(tbl[t].exp));
        chk("vec id", 32'(fid[0]), 32'(tbl[t].id));
        chk("vec latency", 32'(last_fire_cyc - last_gnt_cyc), 32'd2);
      end
    end

    // all four at once, results in round-robin order then pointer wraps
    do_reset();
    set_req(0, OP_AND, 8'hF0, 8'h3C);
    set_req(1, OP_OR,  8'hF0, 8'h0F);
    set_req(2, OP_XOR, 8'hFF, 8'h0F);
    set_req(3, OP_NOT, 8'h00, 8'h00);
    exp_ids = '{0, 1, 2, 3};
    exp_dat = '{8'h30, 8'hFF, 8'hF0, 8'hFF};
    valid = '1; res_ready = 1'b1;
    fid.delete(); fdat.delete();
    n = 0;
    while (fid.size() < 4 && n < 40) begin
      step();
      if (last_gnt >= 0) valid[last_gnt] = 1'b0;
      n++;
    end
    chk("all4 count", 32'(fid.size()), 32'd4);
    for (int i = 0; i < 4 && i < fid.size(); i++) begin
      chk("all4 id", 32'(fid[i]), 32'(exp_ids[i]));
      chk("all4 data", 32'(fdat[i]), 32'(exp_dat[i]));
    end
    valid = 4'b0101;
    step();
    chk("wrap grant", 32'(last_gnt), 32'd0);
    valid = '0;
    repeat (4) step();

    // stall in DONE with other requesters pending
    set_req(2, OP_AND, 8'hCC, 8'hAA);
    valid = 4'b0100; res_ready = 1'b0;
    n = 0;
    while (last_gnt != 2 && n < 10) begin step(); n++; end
    chk("stall grant", 32'(last_gnt), 32'd2);
    valid = 4'b1011;
    repeat (2) step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall res_valid", 32'(res_valid), 32'd1);
      chk("stall res_data", 32'(res_data), 32'h88);
    end
    res_ready = 1'b1;
    step();
    valid = '0;
    step();
    chk("post-stall idle", 32'(res_valid), 32'd0);

    // fairness between requesters 1 and 3
    do_reset();
    valid = 4'b1010; res_ready = 1'b1;
    gnt_q.delete();
    n = 0;
    while (gnt_q.size() < 4 && n < 40) begin step(); n++; end
    chk("fair count", 32'(gnt_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < gnt_q.size(); i++)
      chk("fair order", 32'(gnt_q[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
    valid = '0;
    repeat (4) step();

    // reset during EXEC discards the operation
    do_reset();
    set_req(1, OP_XOR, 8'h3C, 8'hFF);
    valid = 4'b0010;
    n = 0;
    while (last_gnt != 1 && n < 10) begin step(); n++; end
    valid = '0;
    fid.delete(); fdat.delete();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("reset discard", 32'(fid.size()), 32'd0);
    valid = 4'b0010;
    n = 0;
    while (fid.size() == 0 && n < 12) begin
      step();
      if (last_gnt >= 0) valid = '0;
      n++;
    end
    chk("after reset count", 32'(fid.size()), 32'd1);
    if (fid.size() > 0) begin
      chk("after reset id", 32'(fid[0]), 32'd1);
      chk("after reset data", 32'(fdat[0]), 32'hC3);
    end

    // idle period
    valid = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle req_ready", 32'(req_ready), 32'd0);
      chk("idle res_valid", 32'(res_valid), 32'd0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      valid     = N'($urandom);
      opv       = (2*N)'($urandom);
      av        = $urandom;
      bv        = $urandom;
      res_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 60) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
